// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared encodings and defaults for the program-counter sequencer
package pc_seq_pkg;

    localparam int ADDR_W_DEF      = 8;
    localparam int STACK_DEPTH_DEF = 64;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } seq_state_t;

    localparam logic [1:0] FC_NONE   = 2'd0;
    localparam logic [1:0] FC_OVF    = 2'd1;
    localparam logic [1:0] FC_UNF    = 2'd2;
    localparam logic [1:0] FC_STKERR = 2'd3;

endpackage

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC owner and call/return sequencer driving the return-address stack
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int RESET_PC    = 0
) (
    input  logic                               Sys_Clock,
    input  logic                               Reset,
    input  logic                               Stall,
    input  logic                               Halt,
    input  logic                               Resume,
    input  logic                               Jump,
    input  logic                               Call,
    input  logic                               Return,
    input  logic                               Branch_Taken,
    input  logic [ADDR_W-1:0]                  Target,
    input  logic [ADDR_W-1:0]                  Ret_Add,
    input  logic                               Stack_Err,
    output logic [ADDR_W-1:0]                  PC,
    output logic [ADDR_W-1:0]                  NPPC,
    output logic                               Stack_Enable,
    output logic                               Stack_Write,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   Call_Depth,
    output logic                               Halted,
    output logic                               Fault,
    output logic [1:0]                         Fault_Code
);

    localparam int DW = $clog2(STACK_DEPTH+1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

    seq_state_t          state, state_next;
    logic [ADDR_W-1:0]   pc_next;
    logic [DW-1:0]       depth_next;
    logic [1:0]          fc_next;
    logic                run_active;

    assign NPPC       = PC + ADDR_W'(1);
    assign run_active = (state == ST_RUN) && !Stall && !Halt;

    always_ff @(posedge Sys_Clock) begin
        if (Reset) begin
            state      <= ST_RUN;
            PC         <= ADDR_W'(RESET_PC);
            Call_Depth <= '0;
            Fault_Code <= FC_NONE;
        end else begin
            state      <= state_next;
            PC         <= pc_next;
            Call_Depth <= depth_next;
            Fault_Code <= fc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = PC;
        depth_next = Call_Depth;
        fc_next    = Fault_Code;
        case (state)
            ST_RUN: begin
                if (!Stall) begin
                    if (Halt) begin
                        state_next = ST_HALT;
                    end else if (Return) begin
                        if (Call_Depth == '0) begin
                            state_next = ST_FAULT;
                            fc_next    = FC_UNF;
                        end else if (Stack_Err) begin
                            state_next = ST_FAULT;
                            fc_next    = FC_STKERR;
                        end else begin
                            pc_next    = Ret_Add;
                            depth_next = Call_Depth - DW'(1);
                        end
                    end else if (Call) begin
                        if (Call_Depth == DEPTH_MAX) begin
                            state_next = ST_FAULT;
                            fc_next    = FC_OVF;
                        end else if (Stack_Err) begin
                            state_next = ST_FAULT;
                            fc_next    = FC_STKERR;
                        end else begin
                            pc_next    = Target;
                            depth_next = Call_Depth + DW'(1);
                        end
                    end else if (Jump || Branch_Taken) begin
                        pc_next = Target;
                    end else begin
                        pc_next = NPPC;
                    end
                end
            end
            ST_HALT: begin
                if (Resume) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

    // Stack requests depend only on registered state and inputs so they settle before the falling edge.
    always_comb begin
        Stack_Enable = 1'b0;
        Stack_Write  = 1'b0;
        Halted       = (state == ST_HALT);
        Fault        = (state == ST_FAULT);
        if (!Reset && run_active) begin
            if (Return) begin
                Stack_Enable = (Call_Depth != '0);
            end else if (Call) begin
                Stack_Enable = (Call_Depth != DEPTH_MAX);
                Stack_Write  = (Call_Depth != DEPTH_MAX);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - table-driven and directed checks for pc_sequencer
module tb_pc_sequencer;

    logic       sys_clock = 1'b0;
    logic       reset, stall, halt, resume, jump, call, ret, branch_taken, stack_err;
    logic [7:0] target, ret_add, pc, nppc;
    logic       stack_enable, stack_write, halted, fault;
    logic [6:0] call_depth;
    logic [1:0] fault_code;

    int errors = 0;
    int checks = 0;

    always #5 sys_clock = ~sys_clock;

    pc_sequencer dut (
        .Sys_Clock(sys_clock), .Reset(reset), .Stall(stall), .Halt(halt), .Resume(resume),
        .Jump(jump), .Call(call), .Return(ret), .Branch_Taken(branch_taken),
        .Target(target), .Ret_Add(ret_add), .Stack_Err(stack_err),
        .PC(pc), .NPPC(nppc), .Stack_Enable(stack_enable), .Stack_Write(stack_write),
        .Call_Depth(call_depth), .Halted(halted), .Fault(fault), .Fault_Code(fault_code)
    );

    // Behavioural return-address stack acting on the falling edge.
    logic [7:0] stk_mem [0:63];
    int         sp = 0;
    always @(negedge sys_clock) begin
        if (reset) begin
            sp = 0;
        end else if (stack_enable) begin
            if (stack_write) begin
                if (sp < 64) begin
                    stk_mem[sp] = nppc;
                    sp = sp + 1;
                end
            end else if (sp > 0) begin
                sp = sp - 1;
                ret_add = stk_mem[sp];
            end
        end
    end

    typedef struct {
        logic       stall, halt, resume, jump, call, ret, br, err;
        logic [7:0] target;
        logic       exp_se, exp_sw;
        logic [7:0] exp_nppc, exp_pc;
        logic [6:0] exp_depth;
        logic       exp_halted, exp_fault;
        logic [1:0] exp_fc;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; halt = 0; resume = 0; jump = 0; call = 0; ret = 0;
        branch_taken = 0; stack_err = 0; target = 8'h00;
    endtask

    // Called at posedge+1: drive, check combinational outputs before the falling edge, then registered ones.
    task automatic apply(input vec_t v, input string tag);
        stall = v.stall; halt = v.halt; resume = v.resume; jump = v.jump; call = v.call;
        ret = v.ret; branch_taken = v.br; stack_err = v.err; target = v.target;
        #3;
        check({tag, ".stack_enable"}, 32'(stack_enable), 32'(v.exp_se));
        if (v.exp_se) check({tag, ".stack_write"}, 32'(stack_write), 32'(v.exp_sw));
        check({tag, ".nppc"}, 32'(nppc), 32'(v.exp_nppc));
        @(posedge sys_clock); #1;
        check({tag, ".pc"}, 32'(pc), 32'(v.exp_pc));
        check({tag, ".depth"}, 32'(call_depth), 32'(v.exp_depth));
        check({tag, ".halted"}, 32'(halted), 32'(v.exp_halted));
        check({tag, ".fault"}, 32'(fault), 32'(v.exp_fault));
        check({tag, ".fault_code"}, 32'(fault_code), 32'(v.exp_fc));
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        @(posedge sys_clock); #1;
        reset = 0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) @(posedge sys_clock);
        #1;
    endtask

    initial begin
        logic [7:0] exp_pc;
        vec_t v;
        clear_inputs();
        reset = 1;
        ret_add = 8'h00;
        @(posedge sys_clock); #1;

        // Reset wins over a simultaneous Call.
        call = 1; target = 8'h77;
        #3;
        check("reset_call.stack_enable", 32'(stack_enable), 32'd0);
        check("reset_call.stack_write", 32'(stack_write), 32'd0);
        @(posedge sys_clock); #1;
        reset = 0;
        clear_inputs();
        check("reset.pc", 32'(pc), 32'h00);
        check("reset.depth", 32'(call_depth), 32'd0);
        check("reset.halted", 32'(halted), 32'd0);
        check("reset.fault", 32'(fault), 32'd0);
        check("reset.fault_code", 32'(fault_code), 32'd0);

        // Free-running count with wrap.
        exp_pc = 8'h00;
        for (int i = 0; i < 300; i++) begin
            #3;
            check("count.nppc", 32'(nppc), 32'(8'(exp_pc + 8'd1)));
            check("count.stack_enable", 32'(stack_enable), 32'd0);
            @(posedge sys_clock); #1;
            exp_pc = exp_pc + 8'd1;
            check("count.pc", 32'(pc), 32'(exp_pc));
        end
        check("count.final_pc", 32'(pc), 32'h2C);

        do_reset();
        idle(16);
        check("pre_call.pc", 32'(pc), 32'h10);

        //               st ht rs jp cl rt br er tgt     se sw nppc   pc     dp hl ft fc
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 8'h40, 1, 1, 8'h11, 8'h40, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h41, 8'h41, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h42, 8'h42, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h43, 8'h43, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 8'h44, 8'h11, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1, 0, 8'h80, 0, 0, 8'h12, 8'h80, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 8'h20, 1, 1, 8'h81, 8'h20, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0, 8'h55, 1, 0, 8'h21, 8'h81, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 8'h99, 0, 0, 8'h82, 8'h81, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 0, 0, 0, 8'h99, 0, 0, 8'h82, 8'h81, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 8'h99, 0, 0, 8'h82, 8'h81, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h82, 8'h81, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h82, 8'h82, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 8'h83, 8'h83, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 8'h84, 8'h83, 0, 0, 1, 2});
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Fault is absorbing against Call and Jump.
        for (int i = 0; i < 10; i++) begin
            v = '{0, 0, 0, i[0], ~i[0], 0, 0, 0, 8'hC0, 0, 0, 8'h84, 8'h83, 0, 0, 1, 2};
            apply(v, "fault_hold");
        end
        do_reset();
        check("fault_reset.pc", 32'(pc), 32'h00);
        check("fault_reset.fault", 32'(fault), 32'd0);
        check("fault_reset.fault_code", 32'(fault_code), 32'd0);

        // 64 nested calls, then overflow.
        exp_pc = 8'h00;
        for (int i = 0; i < 64; i++) begin
            v = '{0, 0, 0, 0, 1, 0, 0, 0, 8'(8'h40 + i), 1, 1, 8'(exp_pc + 8'd1),
                  8'(8'h40 + i), 7'(i + 1), 0, 0, 0};
            apply(v, "nest");
            exp_pc = 8'(8'h40 + i);
        end
        check("nest.depth64", 32'(call_depth), 32'd64);
        v = '{0, 0, 0, 0, 1, 0, 0, 0, 8'hEE, 0, 0, 8'h80, 8'h7F, 7'd64, 0, 1, 1};
        apply(v, "overflow");

        // Stack error on a legal Call.
        do_reset();
        v = '{0, 0, 0, 0, 1, 0, 0, 0, 8'h30, 1, 1, 8'h01, 8'h30, 1, 0, 0, 0};
        apply(v, "err_setup");
        v = '{0, 0, 0, 0, 1, 0, 0, 1, 8'h60, 1, 1, 8'h31, 8'h30, 1, 0, 1, 3};
        apply(v, "stack_err");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer that sits directly upstream of the return-address stack. It owns PC, drives NPPC (PC+1), and issues push/pop commands to the stack on call/return. It also loads the popped return address back into PC. It tracks call depth and enters a sticky fault state on stack overflow, stack underflow or a stack-reported error.

Parameters:
ADDR_W, 8, width of PC, NPPC, Target and Ret_Add
STACK_DEPTH, 64, number of return-address entries in the downstream stack
RESET_PC, 0, PC value loaded on reset

Ports:
Sys_Clock  in  1  system clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Stall  in  1  hold PC and issue no stack operation this cycle
Halt  in  1  request entry to HALT state
Resume  in  1  leave HALT state
Jump  in  1  unconditional jump to Target
Call  in  1  push NPPC, jump to Target
Return  in  1  pop stack, load PC from Ret_Add
Branch_Taken  in  1  conditional branch resolved taken; jump to Target
Target  in  ADDR_W  jump/call/branch destination
Ret_Add  in  ADDR_W  popped return address from stack
Stack_Err  in  1  stack error flag
PC  out  ADDR_W  current program counter (registered)
NPPC  out  ADDR_W  PC+1, modulo 2^ADDR_W (combinational)
Stack_Enable  out  1  stack operation request (combinational)
Stack_Write  out  1  1 = push, 0 = pop; valid only while Stack_Enable=1
Call_Depth  out  $clog2(STACK_DEPTH+1)  current number of outstanding calls (registered)
Halted  out  1  state == HALT
Fault  out  1  state == FAULT
Fault_Code  out  2  0 none, 1 overflow, 2 underflow, 3 stack error (registered)

Behaviour:
- Reset (synchronous, takes priority over everything):
  - PC=RESET_PC, Call_Depth=0, state=RUN, Fault_Code=0.
  - Stack_Enable=0, Stack_Write=0 during the reset cycle.
- States: RUN, HALT, FAULT. Encoding constants live in the package.
- Stack timing: the stack acts on the falling edge of Sys_Clock within the same cycle. Ret_Add and Stack_Err are therefore valid at the following rising edge. There are no extra wait states.
- RUN, Stall=1: PC, Call_Depth and state hold; Stack_Enable=0. Stall overrides Halt and every control input.
- RUN, Stall=0: first matching row below applies (Halt > Return > Call > Jump > Branch_Taken > default).
  - Halt: state->HALT; PC holds; no stack op.
  - Return, Call_Depth==0: Stack_Enable=0; state->FAULT, Fault_Code=2; PC holds.
  - Return, Call_Depth>0: Stack_Enable=1, Stack_Write=0. At the rising edge:
    - if Stack_Err=1: FAULT, code 3, PC holds.
    - else: PC<=Ret_Add, Call_Depth-1.
  - Call, Call_Depth==STACK_DEPTH: Stack_Enable=0; FAULT, code 1; PC holds.
  - Call, otherwise: Stack_Enable=1, Stack_Write=1; the stack captures NPPC. At the rising edge:
    - if Stack_Err=1: FAULT, code 3, PC holds.
    - else: PC<=Target, Call_Depth+1.
  - Jump or Branch_Taken: PC<=Target.
  - Default: PC<=NPPC. Wraps from 2^ADDR_W-1 to 0.
- Stack_Err is sampled only at the edge ending a cycle with Stack_Enable=1. It is ignored otherwise, including the stack's sticky flag from earlier operations.
- HALT: PC and Call_Depth frozen; Stack_Enable=0. Resume=1 (Stall ignored) -> RUN next cycle. Execution restarts from the held PC.
- FAULT: absorbing; only Reset exits. PC, Call_Depth and Fault_Code frozen; Stack_Enable=0.
- Stack_Enable and Stack_Write are driven purely from registered state plus inputs. They must be stable before the falling edge; inputs are required to settle within the first half-cycle.
- Reset asserted in the same cycle as Call or Return: Stack_Enable=0, so no stack operation is issued; Reset wins.

Decomposition:
- Package pc_seq_pkg holds:
  - state encodings ST_RUN, ST_HALT, ST_FAULT
  - fault codes FC_NONE, FC_OVF, FC_UNF, FC_STKERR
  - default ADDR_W and STACK_DEPTH constants
- No sub-module needed. Next-PC mux, depth counter and FSM are kept in one module, with a separate combinational block for Stack_Enable and Stack_Write.

Test Plan:
1. Reset, then 300 cycles with no controls -> PC counts 0..255 then wraps to 0; NPPC always PC+1 mod 256; Stack_Enable stays 0.
2. At PC=0x10: Call with Target=0x40, then 3 idle cycles, then Return -> during the call cycle Stack_Enable=1, Stack_Write=1, NPPC=0x11; PC=0x40 next cycle; PC steps 0x41..0x43; after the return PC=0x11 and Call_Depth=0.
3. Return with Call_Depth=0 -> Stack_Enable stays 0; Fault=1, Fault_Code=2; PC frozen through 10 cycles of Call/Jump; Reset then restores PC=0, Fault=0.
4. 64 nested Calls -> Call_Depth=64; a 65th Call gives no stack op and Fault_Code=1. A second run forces Stack_Err=1 during a legal Call -> Fault_Code=3; PC holds; depth unchanged.
5. Stall+Call together, then Halt+Jump together, then Resume -> stall cycle has no stack op and PC holds; Halt wins over Jump and Halted=1 with PC held; after Resume, PC increments from the held value.
6. Jump and Branch_Taken asserted together with Target=0x80 -> PC=0x80. Then Return+Call asserted together with depth 1 -> Return wins (pop, Stack_Write=0) and PC loads Ret_Add.
